// File: rtl/outnum_pkg.sv
// ---------------------------------------------------------------------------
// outnum_pkg : shared constants, state encoding and digit encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package outnum_pkg;

  localparam logic [1:0] RADIX_10 = 2'b00;
  localparam logic [1:0] RADIX_16 = 2'b01;
  localparam logic [1:0] RADIX_8  = 2'b10;
  localparam logic [1:0] RADIX_2  = 2'b11;

  localparam logic [7:0] ASCII_ZERO    = 8'd48;
  localparam logic [7:0] ASCII_SPACE   = 8'd32;
  localparam logic [7:0] ASCII_MINUS   = 8'd45;
  localparam logic [7:0] ASCII_UPPER_A = 8'd65;
  localparam logic [7:0] ASCII_LOWER_A = 8'd97;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LATCH      = 3'd1,
    ST_DIV        = 3'd2,
    ST_EMIT_PAD   = 3'd3,
    ST_EMIT_SIGN  = 3'd4,
    ST_EMIT_DIG   = 3'd5,
    ST_EMIT_DELIM = 3'd6
  } state_e;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d, input logic uppercase);
    logic [7:0] letter_base;
    letter_base = uppercase ? ASCII_UPPER_A : ASCII_LOWER_A;
    if (d < 4'd10) digit_to_ascii = ASCII_ZERO + {4'b0000, d};
    else           digit_to_ascii = letter_base + {4'b0000, d} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divmod_by_const_small.sv
// ---------------------------------------------------------------------------
// divmod_by_const_small : restoring divider, one quotient bit per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divmod_by_const_small #(
  parameter int NBITS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] dividend,
  input  logic [3:0]       divisor,
  output logic [NBITS-1:0] quotient,
  output logic [3:0]       remainder,
  output logic             ready
);

  localparam int CNTW = $clog2(NBITS + 1);

  logic [NBITS-1:0] q_q, q_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [4:0]       trial;
  logic [4:0]       diff;
  logic             ge;

  // the quotient register doubles as the dividend shift register
  always_comb begin
    q_d    = q_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, q_q[NBITS-1]};
    diff   = trial - {1'b0, divisor};
    ge     = (trial >= {1'b0, divisor});
    if (start) begin
      q_d    = dividend;
      rem_d  = '0;
      cnt_d  = CNTW'(NBITS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      q_d    = {q_q[NBITS-2:0], ge};
      rem_d  = ge ? diff[3:0] : trial[3:0];
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != CNTW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = rem_q;
  assign ready     = !busy_q;

endmodule

`default_nettype wire

// File: rtl/outnum_radix_postdelims.sv
// ---------------------------------------------------------------------------
// outnum_radix_postdelims : value to ASCII in radix 10/16/8/2 with padding,
// sign and trailing delimiters, streamed over a valid/ready byte port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module outnum_radix_postdelims #(
  parameter int NBITS     = 20,
  parameter int DEPTH     = 20,
  parameter int NDELIMS   = 2,
  parameter int SIGNED    = 0,
  parameter int UPPERCASE = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [NBITS-1:0]                          n,
  input  logic [1:0]                                radix,
  input  logic [4:0]                                minwidth,
  input  logic                                      padzero,
  input  logic [8*((NDELIMS > 0) ? NDELIMS : 1)-1:0] delims,
  input  logic [((NDELIMS > 0) ? NDELIMS : 1)-1:0]   delim_en,
  output logic [7:0]                                outbyte,
  output logic                                      outbyte_valid,
  input  logic                                      outbyte_ready,
  output logic                                      result,
  output logic                                      result_ready
);

  import outnum_pkg::*;

  // with NDELIMS=0 the delimiter ports keep one dummy lane that is never enabled
  localparam int DW  = (NDELIMS > 0) ? NDELIMS : 1;
  localparam int DSW = (DW > 1) ? $clog2(DW) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = (CW > 5) ? CW : 5;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  state_e            state_q, state_d;
  logic [NBITS-1:0]  work_q, work_d;
  logic [1:0]        radix_q, radix_d;
  logic [4:0]        mw_q, mw_d;
  logic              padzero_q, padzero_d;
  logic              neg_q, neg_d;
  logic              trunc_q, trunc_d;
  logic              div_pend_q, div_pend_d;
  logic              result_q, result_d;
  logic [8*DW-1:0]   delims_q, delims_d;
  logic [DW-1:0]     dmask_q, dmask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     pad_q, pad_d;
  logic [3:0]        buf_q [DEPTH];
  logic [3:0]        buf_d [DEPTH];

  logic              step;
  logic [3:0]        step_digit;
  logic [NBITS-1:0]  step_work;
  logic [CW-1:0]     cnt_inc;
  logic [PW-1:0]     mw_clamp;
  logic [PW-1:0]     pad_new;
  logic              div_start;
  logic              div_ready;
  logic [NBITS-1:0]  div_quot;
  logic [3:0]        div_rem;
  logic [DSW-1:0]    dsel;
  logic              xfer;

  divmod_by_const_small #(.NBITS(NBITS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (work_q),
    .divisor   (4'd10),
    .quotient  (div_quot),
    .remainder (div_rem),
    .ready     (div_ready)
  );

  // one digit step: shifts for power-of-two radices, divider round-trip for 10
  always_comb begin
    step       = 1'b0;
    step_digit = '0;
    step_work  = work_q;
    div_start  = 1'b0;
    if (state_q == ST_DIV) begin
      case (radix_q)
        RADIX_16: begin step = 1'b1; step_digit = work_q[3:0];            step_work = work_q >> 4; end
        RADIX_8:  begin step = 1'b1; step_digit = {1'b0, work_q[2:0]};    step_work = work_q >> 3; end
        RADIX_2:  begin step = 1'b1; step_digit = {3'b000, work_q[0]};    step_work = work_q >> 1; end
        default: begin
          div_start  = !div_pend_q;
          step       = div_pend_q && div_ready;
          step_digit = div_rem;
          step_work  = div_quot;
        end
      endcase
    end
  end

  always_comb begin
    dsel = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (dmask_q[i]) dsel = DSW'(i);
    end
  end

  assign cnt_inc  = cnt_q + 1'b1;
  assign mw_clamp = (PW'(mw_q) > DEPTH_P) ? DEPTH_P : PW'(mw_q);
  assign pad_new  = (mw_clamp > PW'(cnt_inc)) ? (mw_clamp - PW'(cnt_inc)) : '0;
  assign xfer     = outbyte_valid && outbyte_ready;

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    radix_d    = radix_q;
    mw_d       = mw_q;
    padzero_d  = padzero_q;
    neg_d      = neg_q;
    trunc_d    = trunc_q;
    div_pend_d = div_pend_q;
    result_d   = result_q;
    delims_d   = delims_q;
    dmask_d    = dmask_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pad_d      = pad_q;
    buf_d      = buf_q;
    case (state_q)
      ST_LATCH: begin
        if ((SIGNED != 0) && (radix_q == RADIX_10) && work_q[NBITS-1]) begin
          neg_d  = 1'b1;
          work_d = '0 - work_q;
        end
        div_pend_d = 1'b0;
        state_d    = ST_DIV;
      end
      ST_DIV: begin
        if (step) begin
          buf_d[cnt_q[AW-1:0]] = step_digit;
          cnt_d      = cnt_inc;
          work_d     = step_work;
          div_pend_d = 1'b0;
          if ((step_work == '0) || (cnt_inc == DEPTH_C)) begin
            trunc_d = (step_work != '0);
            pad_d   = pad_new;
            idx_d   = cnt_q;
            if (padzero_q) state_d = neg_q ? ST_EMIT_SIGN : ((pad_new != '0) ? ST_EMIT_PAD : ST_EMIT_DIG);
            else           state_d = (pad_new != '0) ? ST_EMIT_PAD : (neg_q ? ST_EMIT_SIGN : ST_EMIT_DIG);
          end
        end else if (div_start) begin
          div_pend_d = 1'b1;
        end
      end
      ST_EMIT_PAD: begin
        if (xfer) begin
          pad_d = pad_q - 1'b1;
          if (pad_q == PW'(1)) state_d = (!padzero_q && neg_q) ? ST_EMIT_SIGN : ST_EMIT_DIG;
        end
      end
      ST_EMIT_SIGN: begin
        if (xfer) state_d = (padzero_q && (pad_q != '0)) ? ST_EMIT_PAD : ST_EMIT_DIG;
      end
      ST_EMIT_DIG: begin
        if (xfer) begin
          idx_d = idx_q - 1'b1;
          if (idx_q == '0) begin
            if (dmask_q != '0) begin
              state_d = ST_EMIT_DELIM;
            end else begin
              state_d  = ST_IDLE;
              result_d = !trunc_q;
            end
          end
        end
      end
      ST_EMIT_DELIM: begin
        if (xfer) begin
          dmask_d = dmask_q & (dmask_q - 1'b1);
          if ((dmask_q & (dmask_q - 1'b1)) == '0) begin
            state_d  = ST_IDLE;
            result_d = !trunc_q;
          end
        end
      end
      default: ;
    endcase
    if (start) begin
      work_d     = n;
      radix_d    = radix;
      mw_d       = minwidth;
      padzero_d  = padzero;
      delims_d   = delims;
      dmask_d    = (NDELIMS > 0) ? delim_en : '0;
      cnt_d      = '0;
      neg_d      = 1'b0;
      trunc_d    = 1'b0;
      div_pend_d = 1'b0;
      state_d    = ST_LATCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      radix_q    <= '0;
      mw_q       <= '0;
      padzero_q  <= 1'b0;
      neg_q      <= 1'b0;
      trunc_q    <= 1'b0;
      div_pend_q <= 1'b0;
      result_q   <= 1'b0;
      delims_q   <= '0;
      dmask_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      pad_q      <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      radix_q    <= radix_d;
      mw_q       <= mw_d;
      padzero_q  <= padzero_d;
      neg_q      <= neg_d;
      trunc_q    <= trunc_d;
      div_pend_q <= div_pend_d;
      result_q   <= result_d;
      delims_q   <= delims_d;
      dmask_q    <= dmask_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pad_q      <= pad_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // outputs depend only on registered state, so outbyte holds during stalls
  always_comb begin
    outbyte_valid = 1'b1;
    outbyte       = '0;
    case (state_q)
      ST_EMIT_PAD:   outbyte = padzero_q ? ASCII_ZERO : ASCII_SPACE;
      ST_EMIT_SIGN:  outbyte = ASCII_MINUS;
      ST_EMIT_DIG:   outbyte = digit_to_ascii(buf_q[idx_q[AW-1:0]], UPPERCASE != 0);
      ST_EMIT_DELIM: outbyte = delims_q[8*dsel +: 8];
      default:       outbyte_valid = 1'b0;
    endcase
  end

  assign result       = result_q;
  assign result_ready = (state_q == ST_IDLE) && !start;

endmodule

`default_nettype wire

// File: tb/tb_outnum_radix_postdelims.sv
// ---------------------------------------------------------------------------
// tb_outnum_radix_postdelims : directed vectors against a byte-stream model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_outnum_radix_postdelims;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        ready = 1'b1;
  logic [19:0] n = '0;
  logic [1:0]  radix = '0;
  logic [4:0]  minwidth = '0;
  logic        padzero = 1'b0;
  logic [15:0] delims = '0;
  logic [1:0]  delim_en = '0;
  logic [7:0]  ob0, ob1;
  logic        v0, v1, r0, r1, rr0, rr1;

  always #5 clk = ~clk;

  // instance 0: signed decimal, lowercase hex, full depth
  outnum_radix_postdelims #(.NBITS(20), .DEPTH(20), .NDELIMS(2), .SIGNED(1), .UPPERCASE(0)) u_dut (
    .clk(clk), .reset(reset), .start(start0), .n(n), .radix(radix), .minwidth(minwidth),
    .padzero(padzero), .delims(delims), .delim_en(delim_en), .outbyte(ob0),
    .outbyte_valid(v0), .outbyte_ready(ready), .result(r0), .result_ready(rr0));

  // instance 1: unsigned, uppercase hex, four-digit buffer
  outnum_radix_postdelims #(.NBITS(20), .DEPTH(4), .NDELIMS(2), .SIGNED(0), .UPPERCASE(1)) u_dt (
    .clk(clk), .reset(reset), .start(start1), .n(n), .radix(radix), .minwidth(minwidth),
    .padzero(padzero), .delims(delims), .delim_en(delim_en), .outbyte(ob1),
    .outbyte_valid(v1), .outbyte_ready(ready), .result(r1), .result_ready(rr1));

  int         checks = 0;
  int         failures = 0;
  logic [7:0] q0[$], q1[$], cap0[$], cap1[$];
  bit         active[2];
  bit         exp_res[2];
  bit         prev_stall[2];
  logic [7:0] prev_byte[2];
  string      crlf;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=\"%s\" required=\"%s\"", name, act, exp);
    end
  endtask

  function automatic string qstr(input logic [7:0] s[$]);
    string r = "";
    foreach (s[k]) r = $sformatf("%s%c", r, s[k]);
    return r;
  endfunction

  // Expected byte stream from plain arithmetic on the operands
  task automatic model(input int i, input logic [19:0] nv, input logic [1:0] rdx, input int mw,
                       input bit pz, input logic [15:0] dl, input logic [1:0] den);
    int         base, depth, mwc, pad;
    longint     v;
    bit         neg, up;
    int         ds[$];
    logic [7:0] s[$];
    depth = (i == 0) ? 20 : 4;
    up    = (i == 1);
    base  = (rdx == 2'd0) ? 10 : (rdx == 2'd1) ? 16 : (rdx == 2'd2) ? 8 : 2;
    v     = longint'(nv);
    neg   = 1'b0;
    if (i == 0 && base == 10 && nv[19]) begin
      neg = 1'b1;
      v   = 64'd1048576 - v;
    end
    do begin
      ds.push_front(int'(v % base));
      v = v / base;
    end while (v != 0 && ds.size() < depth);
    exp_res[i] = (v == 0);
    mwc = (mw > depth) ? depth : mw;
    pad = mwc - ds.size();
    if (pad < 0) pad = 0;
    if (!pz) for (int k = 0; k < pad; k++) s.push_back(8'd32);
    if (neg) s.push_back(8'd45);
    if (pz) for (int k = 0; k < pad; k++) s.push_back(8'd48);
    foreach (ds[k]) s.push_back(ds[k] < 10 ? 8'(48 + ds[k]) : 8'((up ? 55 : 87) + ds[k]));
    for (int k = 0; k < 2; k++) if (den[k]) s.push_back(dl[8*k +: 8]);
    if (i == 0) q0 = s; else q1 = s;
  endtask

  task automatic check_port(input int i, input logic v, input logic [7:0] b, input logic res,
                            input logic rr, input logic st);
    int e;
    if (prev_stall[i]) begin
      chk($sformatf("stall_valid_hold%0d", i), v, 1);
      chk($sformatf("stall_byte_hold%0d", i), b, prev_byte[i]);
    end
    prev_stall[i] = v && !ready && !st && !reset;
    prev_byte[i]  = b;
    if (v && !active[i]) chk($sformatf("spurious_valid%0d", i), v, 0);
    if (v && ready && active[i]) begin
      e = -1;
      if (i == 0) begin
        if (q0.size() > 0) e = int'(q0.pop_front());
        cap0.push_back(b);
      end else begin
        if (q1.size() > 0) e = int'(q1.pop_front());
        cap1.push_back(b);
      end
      chk($sformatf("byte%0d", i), b, e);
    end
    if (active[i] && rr && !v) begin
      chk($sformatf("bytes_missing%0d", i), (i == 0) ? q0.size() : q1.size(), 0);
      chk($sformatf("result%0d", i), res, exp_res[i]);
      active[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    check_port(0, v0, ob0, r0, rr0, start0);
    check_port(1, v1, ob1, r1, rr1, start1);
  end

  task automatic kick(input int i, input logic [19:0] nv, input logic [1:0] rdx, input int mw,
                      input bit pz, input logic [15:0] dl, input logic [1:0] den);
    @(posedge clk); #1;
    n = nv; radix = rdx; minwidth = 5'(mw); padzero = pz; delims = dl; delim_en = den; ready = 1'b1;
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    active[i] = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int i, input bit stall, input string name);
    int cyc = 0;
    while (active[i] && cyc < 4000) begin
      if (stall) ready = ($urandom_range(0, 1) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    ready = 1'b1;
    chk({name, "_done"}, active[i], 0);
    active[i] = 1'b0;
  endtask

  task automatic run(input string name, input int i, input logic [19:0] nv, input logic [1:0] rdx,
                     input int mw, input bit pz, input logic [15:0] dl, input logic [1:0] den,
                     input bit stall, input string lit, input bit lres);
    model(i, nv, rdx, mw, pz, dl, den);
    chks({name, "_model"}, (i == 0) ? qstr(q0) : qstr(q1), lit);
    chk({name, "_model_res"}, exp_res[i], lres);
    if (i == 0) cap0.delete(); else cap1.delete();
    kick(i, nv, rdx, mw, pz, dl, den);
    wait_done(i, stall, name);
    chks({name, "_bytes"}, (i == 0) ? qstr(cap0) : qstr(cap1), lit);
  endtask

  initial begin
    int cyc;
    crlf = $sformatf("%c%c", 8'd13, 8'd10);
    active[0] = 0; active[1] = 0;
    prev_stall[0] = 0; prev_stall[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", v0, 0);   chk("rst_outbyte0", ob0, 0);
    chk("rst_result0", r0, 0);  chk("rst_rdy0", rr0, 1);
    chk("rst_valid1", v1, 0);   chk("rst_rdy1", rr1, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    run("dec_crlf",    0, 20'd1234,   2'd0, 0,  0, 16'h0A0D, 2'b11, 0, {"1234", crlf}, 1);
    run("hex_zero",    0, 20'd0,      2'd1, 4,  1, 16'h0A0D, 2'b00, 0, "0000", 1);
    run("neg_space",   0, 20'hFFFF6,  2'd0, 4,  0, 16'h0A20, 2'b01, 0, "  -10 ", 1);
    run("hex_stall",   0, 20'hABCDE,  2'd1, 0,  0, 16'h0000, 2'b00, 1, "abcde", 1);
    run("neg_zeropad", 0, 20'hFFFFB,  2'd0, 3,  1, 16'h0000, 2'b00, 0, "-005", 1);
    run("hex_unsgn",   0, 20'hFFFF6,  2'd1, 0,  0, 16'h0000, 2'b00, 0, "ffff6", 1);
    run("bin",         0, 20'd5,      2'd3, 0,  0, 16'h0000, 2'b00, 0, "101", 1);
    run("oct_stall",   0, 20'hFFFFF,  2'd2, 0,  0, 16'h2C3B, 2'b11, 1, "3777777;,", 1);
    run("trunc_dec",   1, 20'd99999,  2'd0, 0,  0, 16'h0000, 2'b00, 0, "9999", 0);
    run("trunc_hex",   1, 20'hABCDE,  2'd1, 0,  0, 16'h0A0D, 2'b10, 0, {"BCDE", crlf.substr(1, 1)}, 0);
    run("clamp_zero",  1, 20'd1,      2'd3, 31, 1, 16'h0000, 2'b00, 0, "0001", 1);
    run("clamp_space", 1, 20'd1,      2'd3, 31, 0, 16'h0000, 2'b00, 0, "   1", 1);

    // restart during digit emission
    model(0, 20'd555, 2'd0, 0, 0, 16'h0A0D, 2'b11);
    cap0.delete();
    kick(0, 20'd555, 2'd0, 0, 0, 16'h0A0D, 2'b11);
    cyc = 0;
    while (cap0.size() == 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("restart_first_byte", (cap0.size() > 0) ? int'(cap0[0]) : -1, 53);
    ready = 1'b0;
    start0 = 1'b1;
    n = 20'd7;
    model(0, 20'd7, 2'd0, 0, 0, 16'h0A0D, 2'b11);
    cap0.delete();
    @(posedge clk); #1;
    start0 = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("restart_valid_drop", v0, 0);
    wait_done(0, 0, "restart");
    chks("restart_bytes", qstr(cap0), {"7", crlf});

    // reset in the middle of a decimal divide
    model(0, 20'd123456, 2'd0, 0, 0, 16'h0000, 2'b00);
    kick(0, 20'd123456, 2'd0, 0, 0, 16'h0000, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    active[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", v0, 0);
    chk("midrst_rdy", rr0, 1);
    chk("midrst_result", r0, 0);
    chk("midrst_outbyte", ob0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    q0.delete();
    repeat (30) @(posedge clk);
    run("post_reset",  0, 20'd8,      2'd2, 0,  0, 16'h0000, 2'b00, 0, "10", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
